// File: rtl/term_pkg.sv
// Shared constants, control codes and enums for the terminal writer.
package term_pkg;

  // Visible grid; the VRAM address stride is 64 columns by 32 rows.
  localparam int COLS = 60;
  localparam int ROWS = 17;
  localparam logic [7:0] BLANK = 8'h20;

  localparam logic [5:0]  LAST_COL  = 6'(COLS - 1);
  localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
  localparam logic [10:0] LAST_CELL = 11'h7FF;

  // Control codes interpreted by the writer.
  localparam logic [7:0] CR  = 8'h0D;
  localparam logic [7:0] LF  = 8'h0A;
  localparam logic [7:0] BS  = 8'h08;
  localparam logic [7:0] FF  = 8'h0C;
  localparam logic [7:0] DEL = 8'h7F;

  typedef enum logic [2:0] {
    IDLE,
    PUT,
    BKSP,
    NEWLINE,
    CLR_LINE,
    CLR_ALL
  } state_t;

  // Operations the cursor register block can perform in one cycle.
  typedef enum logic [2:0] {
    CUR_HOLD,
    CUR_ADVANCE,
    CUR_BACK,
    CUR_CR,
    CUR_NEWLINE,
    CUR_HOME
  } cur_op_t;

  typedef enum logic [2:0] {
    BYTE_PRINT,
    BYTE_CR,
    BYTE_LF,
    BYTE_BS,
    BYTE_FF,
    BYTE_IGNORE
  } byte_kind_t;

  // Sort an incoming byte into the action it triggers.
  function automatic byte_kind_t classify(input logic [7:0] b);
    byte_kind_t kind;
    if (b == CR)                    kind = BYTE_CR;
    else if (b == LF)               kind = BYTE_LF;
    else if (b == BS)               kind = BYTE_BS;
    else if (b == FF)               kind = BYTE_FF;
    else if (b < 8'h20 || b == DEL) kind = BYTE_IGNORE;
    else                            kind = BYTE_PRINT;
    return kind;
  endfunction

endpackage

// File: rtl/term_cursor.sv
// Cursor position registers. The next position is exposed combinationally
// so the writer can point the VRAM address at the cell the cursor lands on.
module term_cursor
  import term_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  cur_op_t op,
  output logic [5:0] x,
  output logic [4:0] y,
  output logic [5:0] next_x,
  output logic [4:0] next_y
);

  // Apply the requested operation to the current position.
  always_comb begin
    // NOTE: default every output first so no path leaves a value unassigned and infers a latch.
    next_x = x;
    next_y = y;
    case (op)
      CUR_ADVANCE: next_x = x + 6'd1;
      CUR_BACK:    next_x = x - 6'd1;
      CUR_CR:      next_x = 6'd0;
      CUR_NEWLINE: next_y = (y == LAST_ROW) ? 5'd0 : y + 5'd1;
      CUR_HOME: begin
        next_x = 6'd0;
        next_y = 5'd0;
      end
      default: ;
    endcase
  end

  // Position registers; reset homes the cursor.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      x <= 6'd0;
      y <= 5'd0;
    end else begin
      x <= next_x;
      y <= next_y;
    end
  end

endmodule

// File: rtl/term_writer.sv
// Terminal writer: turns a byte stream into VRAM glyph writes, handling
// CR, LF, BS and FF. All VRAM outputs are registered; when idle the address
// holds the cursor cell so the text engine can overlay the cursor.
module term_writer
  import term_pkg::*;
#(
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [10:0] o_vram_addr,
  output logic [7:0]  o_vram_din,
  output logic        o_vram_ce,
  output logic        o_vram_wre,
  output logic        o_vram_clk
);

  state_t     state;
  logic [10:0] k;
  logic       accept;
  byte_kind_t kind;
  cur_op_t    cur_op;
  logic [5:0] cx, next_cx;
  logic [4:0] cy, next_cy;

  assign accept     = i_valid & o_ready;
  assign kind       = classify(i_data);
  assign o_vram_wre = o_vram_ce;
  assign o_vram_clk = i_clk;

  term_cursor u_cursor (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .op     (cur_op),
    .x      (cx),
    .y      (cy),
    .next_x (next_cx),
    .next_y (next_cy)
  );

  // Choose the cursor operation for the current state and input.
  always_comb begin
    cur_op = CUR_HOLD;
    case (state)
      IDLE:    if (accept && kind == BYTE_CR) cur_op = CUR_CR;
      PUT:     cur_op = (cx == LAST_COL) ? CUR_CR : CUR_ADVANCE;
      BKSP:    cur_op = CUR_BACK;
      NEWLINE: cur_op = CUR_NEWLINE;
      CLR_ALL: if (o_vram_ce && k == LAST_CELL) cur_op = CUR_HOME;
      default: cur_op = CUR_HOLD;
    endcase
  end

  // Control FSM with the clear counter and registered VRAM drive. Outputs are
  // loaded on the edge that enters a state, so they describe that state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= CLEAR_ON_RESET ? CLR_ALL : IDLE;
      k           <= 11'd0;
      o_ready     <= 1'b0;
      o_vram_ce   <= 1'b0;
      o_vram_addr <= 11'd0;
      o_vram_din  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          o_ready     <= 1'b1;
          o_vram_ce   <= 1'b0;
          o_vram_addr <= {next_cy, next_cx};
          if (accept) begin
            case (kind)
              BYTE_PRINT: begin
                state       <= PUT;
                o_ready     <= 1'b0;
                o_vram_ce   <= 1'b1;
                o_vram_addr <= {cy, cx};
                o_vram_din  <= i_data;
              end
              BYTE_LF: begin
                state   <= NEWLINE;
                o_ready <= 1'b0;
              end
              BYTE_BS: begin
                if (cx != 6'd0) begin
                  state       <= BKSP;
                  o_ready     <= 1'b0;
                  o_vram_ce   <= 1'b1;
                  o_vram_addr <= {cy, cx - 6'd1};
                  o_vram_din  <= BLANK;
                end
              end
              BYTE_FF: begin
                state       <= CLR_ALL;
                o_ready     <= 1'b0;
                o_vram_ce   <= 1'b1;
                o_vram_addr <= 11'd0;
                o_vram_din  <= BLANK;
                k           <= 11'd0;
              end
              default: ;
            endcase
          end
        end

        PUT: begin
          o_vram_ce <= 1'b0;
          if (cx == LAST_COL) begin
            state <= NEWLINE;
          end else begin
            state       <= IDLE;
            o_ready     <= 1'b1;
            o_vram_addr <= {next_cy, next_cx};
          end
        end

        BKSP: begin
          state       <= IDLE;
          o_ready     <= 1'b1;
          o_vram_ce   <= 1'b0;
          o_vram_addr <= {next_cy, next_cx};
        end

        NEWLINE: begin
          state       <= CLR_LINE;
          k           <= 11'd0;
          o_vram_ce   <= 1'b1;
          o_vram_addr <= {next_cy, 6'd0};
          o_vram_din  <= BLANK;
        end

        CLR_LINE: begin
          if (k[5:0] == LAST_COL) begin
            state       <= IDLE;
            o_ready     <= 1'b1;
            o_vram_ce   <= 1'b0;
            o_vram_addr <= {cy, cx};
          end else begin
            k           <= k + 11'd1;
            o_vram_addr <= {cy, k[5:0] + 6'd1};
          end
        end

        CLR_ALL: begin
          if (!o_vram_ce) begin
            // First cycle after reset: start the sweep at cell 0.
            o_vram_ce   <= 1'b1;
            o_vram_addr <= 11'd0;
            o_vram_din  <= BLANK;
            k           <= 11'd0;
          end else if (k == LAST_CELL) begin
            state       <= IDLE;
            o_ready     <= 1'b1;
            o_vram_ce   <= 1'b0;
            o_vram_addr <= 11'd0;
          end else begin
            k           <= k + 11'd1;
            o_vram_addr <= k + 11'd1;
          end
        end

        default: begin
          state     <= IDLE;
          o_vram_ce <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_term_writer.sv
// Self-checking bench for term_writer: vector table, corner-case sequences
// and random bytes against a cell/cursor reference model.
`timescale 1ns/1ps
module tb_term_writer;

  localparam int MCOLS = 60;
  localparam int MROWS = 17;
  localparam logic [7:0] SP = 8'h20;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [7:0]  i_data = 8'h00;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [10:0] o_vram_addr;
  logic [7:0]  o_vram_din;
  logic        o_vram_ce;
  logic        o_vram_wre;
  logic        o_vram_clk;

  term_writer #(.CLEAR_ON_RESET(1'b1)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .o_vram_addr (o_vram_addr),
    .o_vram_din  (o_vram_din),
    .o_vram_ce   (o_vram_ce),
    .o_vram_wre  (o_vram_wre),
    .o_vram_clk  (o_vram_clk)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_acc = 0;

  typedef struct {
    logic [10:0] addr;
    logic [7:0]  din;
    int          cyc;
  } wr_t;
  wr_t wlog[$];

  logic [7:0] shadow[2048];
  logic [7:0] mvram[2048];
  int mx, my;

  // Cycle counter used for latency measurements.
  always @(posedge i_clk) cyc <= cyc + 1;

  // Passive monitor: log writes into a shadow VRAM, check wre follows ce, count acceptances.
  always @(negedge i_clk) begin
    if (o_vram_ce === 1'b1) begin
      wlog.push_back('{o_vram_addr, o_vram_din, cyc});
      shadow[o_vram_addr] = o_vram_din;
    end
    n_cmp++;
    if (o_vram_wre !== o_vram_ce) begin
      n_bad++;
      $display("FAIL wre_eq_ce: wre=%b ce=%b at cycle %0d", o_vram_wre, o_vram_ce, cyc);
    end
    if (i_valid && o_ready && i_rst_n) n_acc++;
  end

  initial begin
    #950_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_clear();
    for (int i = 0; i < 2048; i++) mvram[i] = SP;
    mx = 0;
    my = 0;
  endtask

  task automatic model_newline(inout int nw);
    my = (my + 1) % MROWS;
    for (int c = 0; c < MCOLS; c++) mvram[my * 64 + c] = SP;
    nw += MCOLS;
  endtask

  task automatic model_apply(input logic [7:0] b, output int nw);
    nw = 0;
    if (b == 8'h0D) mx = 0;
    else if (b == 8'h0A) model_newline(nw);
    else if (b == 8'h08) begin
      if (mx > 0) begin
        mx--;
        mvram[my * 64 + mx] = SP;
        nw = 1;
      end
    end else if (b == 8'h0C) begin
      model_clear();
      nw = 2048;
    end else if (b < 8'h20 || b == 8'h7F) begin
      nw = 0;
    end else begin
      mvram[my * 64 + mx] = b;
      nw = 1;
      if (mx == MCOLS - 1) begin
        mx = 0;
        model_newline(nw);
      end else mx++;
    end
  endtask

  function automatic int vram_diffs();
    int d = 0;
    for (int i = 0; i < 2048; i++) if (shadow[i] !== mvram[i]) d++;
    return d;
  endfunction

  // ---------------- drivers ----------------
  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge i_clk);
      #1;
      if (o_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Send one byte, wait for the writer to return to idle, report what it did.
  task automatic send_byte(input logic [7:0] b, output int nw, output int a0,
                           output int a1, output int d0, output int idle,
                           output int lat, output int mexp);
    bit ok;
    int acc_c;
    nw = 0; a0 = 0; a1 = 0; d0 = 0; idle = 0; lat = 0;
    wait_ready(ok);
    if (!ok) check("ready_before_send", 0, 1);
    wlog.delete();
    i_data = b;
    i_valid = 1'b1;
    @(posedge i_clk);
    #1;
    acc_c = cyc;
    i_valid = 1'b0;
    wait_ready(ok);
    if (!ok) check("ready_after_send", 0, 1);
    nw = wlog.size();
    if (nw > 0) begin
      a0 = int'(wlog[0].addr);
      a1 = int'(wlog[nw - 1].addr);
      d0 = int'(wlog[0].din);
      lat = wlog[0].cyc - acc_c + 1;
    end
    idle = int'(o_vram_addr);
    model_apply(b, mexp);
  endtask

  typedef struct {
    logic [7:0] data;
    int nw;
    int a0;
    int a1;
    int d0;
    int idle;
  } vec_t;

  vec_t vecs[13];

  initial begin
    bit ok;
    int nw, a0, a1, d0, idle, lat, mexp, bad_seq, nlog;
    logic [7:0] b;
    logic [7:0] ign[5];

    // ---------- reset state and power-up clear with i_valid held ----------
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    #1;
    check("rst_ready", o_ready, 0);
    check("rst_ce", o_vram_ce, 0);
    check("rst_addr", o_vram_addr, 0);
    check("rst_din", o_vram_din, 0);
    wlog.delete();
    n_acc = 0;
    i_data = 8'h51;
    i_valid = 1'b1;
    i_rst_n = 1'b1;
    wait_ready(ok);
    check("clr_all_done", ok, 1);
    check("clr_all_count", wlog.size(), 2048);
    bad_seq = 0;
    for (int i = 0; i < wlog.size() && i < 2048; i++)
      if (wlog[i].addr !== 11'(i) || wlog[i].din !== SP) bad_seq++;
    check("clr_all_seq", bad_seq, 0);
    check("clr_all_idle_addr", o_vram_addr, 0);
    check("accept_only_when_ready", n_acc, 1);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    wait_ready(ok);
    check("held_byte_writes", wlog.size(), 2049);
    if (wlog.size() == 2049) begin
      check("held_byte_addr", wlog[2048].addr, 0);
      check("held_byte_din", wlog[2048].din, 8'h51);
    end
    check("held_byte_idle", o_vram_addr, 11'h001);
    model_clear();
    model_apply(8'h51, mexp);

    // ---------- vector table ----------
    vecs[0]  = '{8'h0C, 2048, 11'h000, 11'h7FF, 8'h20, 11'h000};
    vecs[1]  = '{8'h41, 1,    11'h000, 11'h000, 8'h41, 11'h001};
    vecs[2]  = '{8'h07, 0,    0,       0,       0,     11'h001};
    vecs[3]  = '{8'h0D, 0,    0,       0,       0,     11'h000};
    vecs[4]  = '{8'h0A, 60,   11'h040, 11'h07B, 8'h20, 11'h040};
    vecs[5]  = '{8'h0A, 60,   11'h080, 11'h0BB, 8'h20, 11'h080};
    vecs[6]  = '{8'h08, 0,    0,       0,       0,     11'h080};
    vecs[7]  = '{8'h61, 1,    11'h080, 11'h080, 8'h61, 11'h081};
    vecs[8]  = '{8'h62, 1,    11'h081, 11'h081, 8'h62, 11'h082};
    vecs[9]  = '{8'h63, 1,    11'h082, 11'h082, 8'h63, 11'h083};
    vecs[10] = '{8'h08, 1,    11'h082, 11'h082, 8'h20, 11'h082};
    vecs[11] = '{8'h7F, 0,    0,       0,       0,     11'h082};
    vecs[12] = '{8'h1B, 0,    0,       0,       0,     11'h082};
    for (int i = 0; i < 13; i++) begin
      send_byte(vecs[i].data, nw, a0, a1, d0, idle, lat, mexp);
      check($sformatf("vec%0d_nwrites", i), nw, vecs[i].nw);
      if (vecs[i].nw > 0) begin
        check($sformatf("vec%0d_first_addr", i), a0, vecs[i].a0);
        check($sformatf("vec%0d_last_addr", i), a1, vecs[i].a1);
        check($sformatf("vec%0d_first_din", i), d0, vecs[i].d0);
      end
      if (vecs[i].nw == 1) check($sformatf("vec%0d_latency", i), lat, 1);
      check($sformatf("vec%0d_idle_addr", i), idle, vecs[i].idle);
    end

    // ---------- 60 glyphs from (0,0): wrap to row 1 and clear it ----------
    send_byte(8'h0C, nw, a0, a1, d0, idle, lat, mexp);
    for (int i = 0; i < 59; i++) begin
      send_byte(8'h41, nw, a0, a1, d0, idle, lat, mexp);
      if (i == 0 || i == 58) check($sformatf("row_fill_idle_%0d", i), idle, i + 1);
    end
    send_byte(8'h41, nw, a0, a1, d0, idle, lat, mexp);
    check("wrap_nwrites", nw, 61);
    check("wrap_put_addr", a0, 11'h03B);
    if (wlog.size() > 1) check("wrap_clr_first", wlog[1].addr, 11'h040);
    check("wrap_clr_last", a1, 11'h07B);
    check("wrap_idle_addr", idle, 11'h040);

    // ---------- LF from (5,16): ring wrap clears row 0 ----------
    send_byte(8'h0C, nw, a0, a1, d0, idle, lat, mexp);
    for (int i = 0; i < 16; i++) send_byte(8'h0A, nw, a0, a1, d0, idle, lat, mexp);
    for (int i = 0; i < 5; i++) send_byte(8'h78, nw, a0, a1, d0, idle, lat, mexp);
    check("row16_idle_addr", idle, 11'h405);
    send_byte(8'h0A, nw, a0, a1, d0, idle, lat, mexp);
    check("ringwrap_nwrites", nw, 60);
    check("ringwrap_first", a0, 11'h000);
    check("ringwrap_last", a1, 11'h03B);
    check("ringwrap_idle_addr", idle, 11'h005);
    check("vram_after_ringwrap", vram_diffs(), 0);

    // ---------- reset asserted mid CLR_LINE ----------
    wait_ready(ok);
    i_data = 8'h0A;
    i_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    repeat (12) @(negedge i_clk);
    #1;
    check("mid_clr_line_ce", o_vram_ce, 1);
    i_rst_n = 1'b0;
    @(posedge i_clk);
    #1;
    nlog = wlog.size();
    @(negedge i_clk);
    #1;
    check("abort_ce", o_vram_ce, 0);
    check("abort_ready", o_vram_ce | o_ready, 0);
    check("abort_addr", o_vram_addr, 0);
    @(negedge i_clk);
    #1;
    check("abort_no_writes", wlog.size(), nlog);
    i_rst_n = 1'b1;
    wait_ready(ok);
    check("abort_reclear_done", ok, 1);
    check("abort_home_addr", o_vram_addr, 0);
    model_clear();
    check("vram_after_abort", vram_diffs(), 0);

    // ---------- random bytes against the model ----------
    ign[0] = 8'h00; ign[1] = 8'h07; ign[2] = 8'h1B; ign[3] = 8'h7F; ign[4] = 8'h1F;
    for (int n = 0; n < 300; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 65)      b = 8'($urandom_range(32, 126));
      else if (r < 75) b = 8'h0A;
      else if (r < 82) b = 8'h0D;
      else if (r < 91) b = 8'h08;
      else if (r < 92) b = 8'h0C;
      else             b = ign[$urandom_range(0, 4)];
      send_byte(b, nw, a0, a1, d0, idle, lat, mexp);
      check($sformatf("rnd%0d_nwrites_b%02h", n, b), nw, mexp);
      check($sformatf("rnd%0d_idle_b%02h", n, b), idle, my * 64 + mx);
      if (n % 25 == 24) check($sformatf("rnd%0d_vram", n), vram_diffs(), 0);
    end
    check("final_vram", vram_diffs(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
